// File: rtl/nios_project_pwm_leds.sv
// -----------------------------------------------------------------------------
// nios_project_pwm_leds
//
// Avalon-MM slave that drives WIDTH LED channels. Each channel is a plain
// output bit (DATA) that can optionally be gated by a shared PWM waveform.
// The PWM runs from a 16-bit prescaler that produces a one-cycle tick. Each
// tick advances an 8-bit period counter. The duty value is shadowed, so a
// new duty setting only takes effect at the next period boundary.
//
// Register map (word addresses):
//   0 DATA      R/W  WIDTH bits
//   1 SET       W    DATA |= wdata   (reads 0)
//   2 CLR       W    DATA &= ~wdata  (reads 0)
//   3 TOGGLE    W    DATA ^= wdata   (reads 0)
//   4 PWM_EN    R/W  WIDTH bits, 1 = channel gated by PWM
//   5 PRESCALE  R/W  16 bits, tick period is PRESCALE+1 cycles
//   6 DUTY      R/W  8 bits, high counts per 256-count period
//   7 STATUS    RO   [7:0] pwm_cnt, [15:8] duty_active
//
// Ports:
//   clk         single clock for all logic
//   reset_n     synchronous active-low reset
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (bits above a register's width are ignored)
//   readdata    combinational read data, zero-extended
//   out_port    registered channel outputs
// -----------------------------------------------------------------------------
module nios_project_pwm_leds #(
    parameter int unsigned       WIDTH          = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE    = '0,
    parameter logic [15:0]       PRESCALE_RESET = 16'd999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_SET      = 3'd1;
    localparam logic [2:0] ADDR_CLR      = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd3;
    localparam logic [2:0] ADDR_PWM_EN   = 3'd4;
    localparam logic [2:0] ADDR_PRESCALE = 3'd5;
    localparam logic [2:0] ADDR_DUTY     = 3'd6;
    localparam logic [2:0] ADDR_STATUS   = 3'd7;

    // Register state
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] pwm_en;
    logic [15:0]      prescale;
    logic [7:0]       duty;

    // PWM engine state
    logic [15:0]      prescale_cnt;
    logic [7:0]       pwm_cnt;
    logic [7:0]       duty_active;

    // Decode
    logic             wr_en;
    logic             wr_data;
    logic             wr_set;
    logic             wr_clr;
    logic             wr_toggle;
    logic             wr_pwm_en;
    logic             wr_prescale;
    logic             wr_duty;
    logic [WIDTH-1:0] wdata_w;

    // Next-state helpers
    logic [WIDTH-1:0] data_next;
    logic             tick;
    logic             period_wrap;
    logic             pwm_on;
    logic [WIDTH-1:0] out_next;

    // Upper write-data bits have no destination in any register.
    logic             unused_wdata;
    assign unused_wdata = ^writedata[31:16];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign wr_en       = chipselect & ~write_n;
    assign wr_data     = wr_en & (address == ADDR_DATA);
    assign wr_set      = wr_en & (address == ADDR_SET);
    assign wr_clr      = wr_en & (address == ADDR_CLR);
    assign wr_toggle   = wr_en & (address == ADDR_TOGGLE);
    assign wr_pwm_en   = wr_en & (address == ADDR_PWM_EN);
    assign wr_prescale = wr_en & (address == ADDR_PRESCALE);
    assign wr_duty     = wr_en & (address == ADDR_DUTY);
    assign wdata_w     = writedata[WIDTH-1:0];

    // Only one write can be in flight per cycle, so the DATA update
    // sources are mutually exclusive.
    always_comb begin
        data_next = data;
        if (wr_data) begin
            data_next = wdata_w;
        end else if (wr_set) begin
            data_next = data | wdata_w;
        end else if (wr_clr) begin
            data_next = data & ~wdata_w;
        end else if (wr_toggle) begin
            data_next = data ^ wdata_w;
        end
    end

    // ------------------------------------------------------------------
    // PWM timing
    // ------------------------------------------------------------------
    // A PRESCALE write restarts the count and swallows a tick that would
    // otherwise have fired on the same edge.
    assign tick        = (prescale_cnt == 16'd0) & ~wr_prescale;
    assign period_wrap = tick & (pwm_cnt == 8'hFF);
    assign pwm_on      = (pwm_cnt < duty_active);

    // Channels with PWM disabled pass DATA straight through.
    assign out_next    = data & (~pwm_en | {WIDTH{pwm_on}});

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data     <= RESET_VALUE;
            pwm_en   <= '0;
            prescale <= PRESCALE_RESET;
            duty     <= 8'd0;
        end else begin
            data <= data_next;
            if (wr_pwm_en) begin
                pwm_en <= wdata_w;
            end
            if (wr_prescale) begin
                prescale <= writedata[15:0];
            end
            if (wr_duty) begin
                duty <= writedata[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler, period counter and duty shadow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescale_cnt <= PRESCALE_RESET;
            pwm_cnt      <= 8'd0;
            duty_active  <= 8'd0;
        end else begin
            if (wr_prescale) begin
                prescale_cnt <= writedata[15:0];
            end else if (prescale_cnt == 16'd0) begin
                prescale_cnt <= prescale;
            end else begin
                prescale_cnt <= prescale_cnt - 16'd1;
            end

            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end

            // Sample DUTY only at the period boundary so a period is never
            // cut short or stretched by a mid-period write.
            if (period_wrap) begin
                duty_active <= duty;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= out_next;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = data;
            ADDR_PWM_EN:   readdata[WIDTH-1:0] = pwm_en;
            ADDR_PRESCALE: readdata[15:0]      = prescale;
            ADDR_DUTY:     readdata[7:0]       = duty;
            ADDR_STATUS:   readdata[15:0]      = {duty_active, pwm_cnt};
            default:       readdata            = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_nios_project_pwm_leds.sv
module tb_nios_project_pwm_leds;

    localparam int         W   = 4;
    localparam logic [3:0] RV  = 4'hA;
    localparam int         PRV = 999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd7;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [W-1:0] out_port;

    int n_checks = 0;
    int n_fail   = 0;

    nios_project_pwm_leds #(
        .WIDTH(W),
        .RESET_VALUE(RV),
        .PRESCALE_RESET(16'd999)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: tick period counted upward as elapsed cycles
    // since the last reload; period position and duty shadow as integers.
    // ------------------------------------------------------------------
    bit         m_valid = 0;
    int         m_data, m_en, m_pre, m_elapsed, m_duty, m_da, m_cnt, m_out;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_data = RV; m_en = 0; m_pre = PRV; m_elapsed = 0;
            m_duty = 0; m_da = 0; m_cnt = 0; m_out = 0;
            m_valid = 1;
        end else if (m_valid) begin
            bit wr, wpre, tk;
            int mask;
            mask = (1 << W) - 1;
            m_out = 0;
            for (int i = 0; i < W; i++)
                if (((m_data >> i) & 1) && (!((m_en >> i) & 1) || (m_cnt < m_da)))
                    m_out |= (1 << i);
            wr   = chipselect && !write_n;
            wpre = wr && (address == 3'd5);
            tk   = (m_elapsed == m_pre) && !wpre;
            if (wpre) begin
                m_pre = writedata[15:0]; m_elapsed = 0;
            end else if (m_elapsed == m_pre) m_elapsed = 0;
            else m_elapsed++;
            if (tk) begin
                if (m_cnt == 255) m_da = m_duty;
                m_cnt = (m_cnt + 1) % 256;
            end
            if (wr) begin
                case (address)
                    3'd0: m_data = writedata & mask;
                    3'd1: m_data = m_data | (writedata & mask);
                    3'd2: m_data = m_data & ~(writedata & mask) & mask;
                    3'd3: m_data = (m_data ^ writedata) & mask;
                    3'd4: m_en   = writedata & mask;
                    3'd6: m_duty = writedata[7:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_data;
            3'd4: return m_en;
            3'd5: return m_pre;
            3'd6: return m_duty;
            3'd7: return (m_da << 8) | m_cnt;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_out_port", 32'(out_port), m_out);
            check("model_readdata", readdata, m_read(address));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd7;
    endtask

    task automatic wait_duty(input int v);
        bit ok = 0;
        address = 3'd7;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (readdata[15:8] == v[7:0]) begin ok = 1; break; end
        end
        if (!ok) check("wait_duty_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cnt(input int v);
        bit ok = 0;
        address = 3'd7;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (readdata[7:0] == v[7:0]) begin ok = 1; break; end
        end
        if (!ok) check("wait_cnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_high(output int hi, output int bad);
        hi = 0; bad = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            hi += int'(out_port[0]);
            if (out_port[3:1] != 3'b111) bad++;
        end
    endtask

    // Called at a negedge with address=7; counts edges until pwm_cnt moves.
    task automatic measure(output int n);
        logic [7:0] c0;
        bit ok = 0;
        c0 = readdata[7:0];
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (readdata[7:0] != c0) begin ok = 1; break; end
        end
        if (!ok) check("measure_timeout", 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int hi, bad, n, done, do_wr, chk_mid;
        logic [7:0] c0;
        logic [31:0] exp_rd [8];
        exp_rd = '{32'hA, 0, 0, 0, 0, 999, 0, 0};

        // Reset then read back every address
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_out_port", 32'(out_port), 32'hA);
        for (int a = 0; a < 8; a++) begin
            address = a[2:0];
            @(negedge clk);
            check($sformatf("reset_read_%0d", a), readdata, exp_rd[a]);
        end

        // Set / clear / toggle, writes on consecutive edges
        @(posedge clk); #1;
        wr(3'd0, 32'h3);
        wr(3'd1, 32'h8);
        check("seq_data", 32'(out_port), 32'h3);
        wr(3'd2, 32'h1);
        check("seq_set", 32'(out_port), 32'hB);
        wr(3'd3, 32'h6);
        check("seq_clr", 32'(out_port), 32'hA);
        @(posedge clk); #1;
        check("seq_toggle", 32'(out_port), 32'hC);
        address = 3'd1;
        #1 check("set_reads_zero", readdata, 32'd0);

        // PWM duty 64 on channel 0
        wr(3'd5, 32'd0);
        wr(3'd0, 32'hF);
        wr(3'd4, 32'h1);
        wr(3'd6, 32'd64);
        wait_duty(64);
        count_high(hi, bad);
        check("duty64_high", hi, 32'd64);
        check("duty64_other_bits", bad, 32'd0);

        // Duty shadowing: write 192 while pwm_cnt=10
        wait_cnt(0);
        hi = 0; done = 0; do_wr = 0; chk_mid = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            if (do_wr != 0) begin
                address = 3'd6; writedata = 32'd192; chipselect = 1'b1; write_n = 1'b0;
            end else begin
                address = 3'd7; chipselect = 1'b0; write_n = 1'b1;
            end
            @(negedge clk);
            hi += int'(out_port[0]);
            if (do_wr != 0) begin
                do_wr = 0; done = 1;
            end else if (done != 0 && chk_mid == 0) begin
                check("shadow_hold", 32'(readdata[15:8]), 32'd64);
                chk_mid = 1;
            end else if (done == 0 && readdata[7:0] == 8'd9) begin
                do_wr = 1;
            end
        end
        check("shadow_period_high", hi, 32'd64);
        check("shadow_load", 32'(readdata[15:8]), 32'd192);
        count_high(hi, bad);
        check("duty192_high", hi, 32'd192);

        // Prescaler reload
        @(posedge clk); #1;
        wr(3'd5, 32'd3);
        @(negedge clk);
        measure(n);
        measure(n);
        check("prescale3_interval", n, 32'd4);
        c0 = readdata[7:0];
        @(posedge clk); #1;
        address = 3'd5; writedata = 32'd1; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd7;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (readdata[7:0] != c0) break;
            @(posedge clk); n++;
        end
        check("prescale_reload_first", n, 32'd2);
        measure(n);
        check("prescale1_interval", n, 32'd2);

        // Extremes
        @(posedge clk); #1;
        wr(3'd5, 32'd0);
        wr(3'd6, 32'd0);
        wait_duty(0);
        count_high(hi, bad);
        check("duty0_high", hi, 32'd0);
        @(posedge clk); #1;
        wr(3'd6, 32'd255);
        wait_duty(255);
        count_high(hi, bad);
        check("duty255_high", hi, 32'd255);

        // Reset mid-period, with a write presented during reset
        wait_cnt(100);
        @(posedge clk); #1;
        reset_n = 1'b0;
        address = 3'd0; writedata = 32'h5; chipselect = 1'b1; write_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd7;
        @(posedge clk);
        @(negedge clk);
        check("midreset_out_port", 32'(out_port), 32'hA);
        check("midreset_status", readdata, 32'd0);
        address = 3'd0;
        #1 check("reset_write_ignored", readdata, 32'hA);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1);
    end

endmodule
